// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared types and constants for the arithmetic engines
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } div_state_t;

  // Quotient reported on divide-by-zero; sliced to the engine width.
  localparam logic [31:0] QUOT_DBZ = 32'hFFFF_FFFF;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/restoring_divider_seq_if.sv
// rtl/restoring_divider_seq_if.sv - start/busy/done handshake and operand/result bus of the divider
interface restoring_divider_seq_if #(
  parameter int WIDTH = 8
) ();

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/restoring_div_step.sv
// rtl/restoring_div_step.sv - one combinational shift/subtract/restore iteration
module restoring_div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   a_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH:0]   a_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0]   a_sh;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH:0]   trial;

  // A stays below M, so its top bit is always clear and may be shifted out.
  assign a_sh  = {a_i[WIDTH-1:0], q_i[WIDTH-1]};
  assign q_sh  = {q_i[WIDTH-2:0], 1'b0};
  assign trial = a_sh - {1'b0, m_i};

  always_comb begin
    a_o = a_sh;
    q_o = q_sh;
    if (!trial[WIDTH]) begin
      a_o = trial;
      q_o = {q_sh[WIDTH-1:1], 1'b1};
    end
  end

endmodule

// File: rtl/restoring_divider_seq.sv
// rtl/restoring_divider_seq.sv - sequential unsigned restoring divider, one quotient bit per clock
module restoring_divider_seq
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  restoring_divider_seq_if.slave  bus
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] ALL_ONES = QUOT_DBZ[WIDTH-1:0];

  div_state_t       state_q, state_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   step_a;
  logic [WIDTH-1:0] step_q;

  restoring_div_step #(.WIDTH(WIDTH)) u_step (
    .a_i (a_q),
    .q_i (q_q),
    .m_i (m_q),
    .a_o (step_a),
    .q_o (step_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        // The done cycle is spent in IDLE; a start seen then is ignored.
        if (bus.start && !done_q) begin
          m_d     = bus.divisor;
          q_d     = bus.dividend;
          a_d     = '0;
          cnt_d   = CNT_W'(WIDTH);
          busy_d  = 1'b1;
          state_d = (bus.divisor == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        a_d   = step_a;
        q_d   = step_q;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = FIN;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
        if (m_q == '0) begin
          quot_d = ALL_ONES;
          rem_d  = q_q;
          dbz_d  = 1'b1;
        end else begin
          quot_d = q_q;
          rem_d  = a_q[WIDTH-1:0];
          dbz_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider_seq.sv
// tb/tb_restoring_divider_seq.sv - self-checking bench driving an 8-bit and a 16-bit divider in parallel
module tb_restoring_divider_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dvd_in;
  logic [15:0] dvs_in;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;

  restoring_divider_seq_if #(.WIDTH(8))  bus8 ();
  restoring_divider_seq_if #(.WIDTH(16)) bus16 ();

  assign bus8.start     = start;
  assign bus8.dividend  = dvd_in[7:0];
  assign bus8.divisor   = dvs_in[7:0];
  assign bus16.start    = start;
  assign bus16.dividend = dvd_in;
  assign bus16.divisor  = dvs_in;

  restoring_divider_seq #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  restoring_divider_seq #(.WIDTH(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0d expected %0d (edge %0d)", name, d, act, exp, cyc);
    end
  endtask

  // Reference model: per divider, the edge a start is accepted, the edge done
  // must appear, and the arithmetic result the outputs must show from then on.
  int          acc_at  [2];
  int          done_at [2];
  int          next_acc[2];
  logic [15:0] op_a[2], op_b[2];
  logic [15:0] pq[2], pr[2], eq[2], er[2];
  logic        pz[2], ez[2];
  logic [15:0] mask;
  int          width;

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int d = 0; d < 2; d++) begin
      mask  = (d == 0) ? 16'h00FF : 16'hFFFF;
      width = (d == 0) ? 8 : 16;
      if (rst) begin
        acc_at[d]   = -10;
        done_at[d]  = -10;
        next_acc[d] = cyc + 1;
        eq[d] = '0; er[d] = '0; ez[d] = 1'b0;
      end else begin
        if (cyc == done_at[d]) begin
          eq[d] = pq[d]; er[d] = pr[d]; ez[d] = pz[d];
        end
        if (start && cyc >= next_acc[d]) begin
          op_a[d]   = dvd_in & mask;
          op_b[d]   = dvs_in & mask;
          acc_at[d] = cyc;
          if (op_b[d] == 16'd0) begin
            pq[d] = mask; pr[d] = op_a[d]; pz[d] = 1'b1;
            done_at[d] = cyc + 1;
          end else begin
            pq[d] = op_a[d] / op_b[d]; pr[d] = op_a[d] % op_b[d]; pz[d] = 1'b0;
            done_at[d] = cyc + width + 1;
          end
          // done occupies one IDLE cycle in which start is still ignored
          next_acc[d] = done_at[d] + 2;
        end
      end
    end
  end

  logic [15:0] aq, ar;
  logic        ab, ad, az;

  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int d = 0; d < 2; d++) begin
        if (d == 0) begin
          aq = {8'h00, bus8.quotient}; ar = {8'h00, bus8.remainder};
          ab = bus8.busy; ad = bus8.done; az = bus8.div_by_zero;
        end else begin
          aq = bus16.quotient; ar = bus16.remainder;
          ab = bus16.busy; ad = bus16.done; az = bus16.div_by_zero;
        end
        chk("busy", d, 32'(ab), 32'(cyc >= acc_at[d] && cyc < done_at[d]));
        chk("done", d, 32'(ad), 32'(cyc == done_at[d]));
        chk("quotient", d, 32'(aq), 32'(eq[d]));
        chk("remainder", d, 32'(ar), 32'(er[d]));
        chk("div_by_zero", d, 32'(az), 32'(ez[d]));
        if (ad && op_b[d] != 16'd0) begin
          chk("invariant", d, 32'(aq) * 32'(op_b[d]) + 32'(ar), 32'(op_a[d]));
          chk("rem_lt_div", d, 32'(ar < op_b[d]), 32'd1);
        end
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    start  = 1'b1;
    dvd_in = a;
    dvs_in = b;
    @(negedge clk);
    t0    = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done8(input int budget, output int lat);
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      if (bus8.done) begin
        lat = cyc - t0;
        break;
      end
      @(negedge clk);
    end
    chk("done8_seen", 0, 32'(lat >= 0), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (!bus8.busy && !bus16.busy && !bus8.done && !bus16.done) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    chk("idle_reached", 0, 32'(ok), 32'd1);
  endtask

  initial begin
    int lat;
    logic [15:0] a, b;
    rst = 1'b1; start = 1'b0; dvd_in = '0; dvs_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 0, 32'(bus8.busy), 32'd0);
    chk("rst_quot", 0, 32'(bus8.quotient), 32'd0);
    chk("rst_rem", 0, 32'(bus8.remainder), 32'd0);
    chk("rst_dbz", 0, 32'(bus8.div_by_zero), 32'd0);
    @(negedge clk);

    issue(16'd100, 16'd7);
    wait_done8(20, lat);
    chk("t1_lat", 0, 32'(lat), 32'd9);
    chk("t1_quot", 0, 32'(bus8.quotient), 32'd14);
    chk("t1_rem", 0, 32'(bus8.remainder), 32'd2);
    chk("t1_dbz", 0, 32'(bus8.div_by_zero), 32'd0);
    wait_idle(30);

    issue(16'd255, 16'd1);
    wait_done8(20, lat);
    chk("t2a_quot", 0, 32'(bus8.quotient), 32'd255);
    chk("t2a_rem", 0, 32'(bus8.remainder), 32'd0);
    @(negedge clk);
    issue(16'd5, 16'd9);
    wait_done8(20, lat);
    chk("t2b_lat", 0, 32'(lat), 32'd9);
    chk("t2b_quot", 0, 32'(bus8.quotient), 32'd0);
    chk("t2b_rem", 0, 32'(bus8.remainder), 32'd5);
    wait_idle(30);

    issue(16'd37, 16'd0);
    wait_done8(20, lat);
    chk("t3_lat", 0, 32'(lat), 32'd1);
    chk("t3_quot", 0, 32'(bus8.quotient), 32'hFF);
    chk("t3_rem", 0, 32'(bus8.remainder), 32'd37);
    chk("t3_dbz", 0, 32'(bus8.div_by_zero), 32'd1);
    @(negedge clk);
    issue(16'd200, 16'd10);
    wait_done8(20, lat);
    chk("t3b_lat", 0, 32'(lat), 32'd9);
    chk("t3b_quot", 0, 32'(bus8.quotient), 32'd20);
    chk("t3b_rem", 0, 32'(bus8.remainder), 32'd0);
    chk("t3b_dbz", 0, 32'(bus8.div_by_zero), 32'd0);
    wait_idle(30);

    // start held high with changing operands throughout the division
    start = 1'b1; dvd_in = 16'd50; dvs_in = 16'd3;
    @(negedge clk);
    t0 = cyc;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      if (bus8.done) begin
        lat = cyc - t0;
        break;
      end
      dvd_in = 16'($urandom_range(0, 65535));
      dvs_in = 16'($urandom_range(1, 65535));
      @(negedge clk);
    end
    chk("t4_lat", 0, 32'(lat), 32'd9);
    chk("t4_quot", 0, 32'(bus8.quotient), 32'd16);
    chk("t4_rem", 0, 32'(bus8.remainder), 32'd2);
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_idle(40);

    issue(16'd100, 16'd7);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_busy", 0, 32'(bus8.busy), 32'd0);
    chk("t5_done", 0, 32'(bus8.done), 32'd0);
    chk("t5_quot", 0, 32'(bus8.quotient), 32'd0);
    chk("t5_rem", 0, 32'(bus8.remainder), 32'd0);
    repeat (12) @(negedge clk);
    issue(16'd100, 16'd7);
    wait_done8(20, lat);
    chk("t5b_lat", 0, 32'(lat), 32'd9);
    chk("t5b_quot", 0, 32'(bus8.quotient), 32'd14);
    chk("t5b_rem", 0, 32'(bus8.remainder), 32'd2);
    wait_idle(30);

    issue(16'hFFFF, 16'hFFFF);
    wait_idle(40);
    issue(16'd0, 16'd5);
    wait_idle(40);
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom_range(0, 65535));
      if (i % 5 == 0)      b = 16'd0;
      else if (i % 3 == 0) b = 16'($urandom_range(1, 20));
      else                 b = 16'($urandom_range(1, 65535));
      issue(a, b);
      wait_idle(40);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
